// File: rtl/fifo_pkt_reader_if.sv
// Bundles the FIFO read side, the UDP TX request handshake and the byte stream
// of the packet reader; master = reader, slave = its environment.
interface fifo_pkt_reader_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 11
);
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   fifo_rd_empty;
    logic [DEPTH_WIDTH:0]   fifo_water_level;
    logic                   fifo_rd_en;

    logic                   pkt_req;
    logic [15:0]            pkt_len;
    logic                   pkt_ack;

    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_valid;
    logic                   m_last;
    logic                   m_ready;

    logic                   busy;

    modport master (
        input  fifo_rd_data, fifo_rd_empty, fifo_water_level, pkt_ack, m_ready,
        output fifo_rd_en, pkt_req, pkt_len, m_data, m_valid, m_last, busy
    );

    modport slave (
        output fifo_rd_data, fifo_rd_empty, fifo_water_level, pkt_ack, m_ready,
        input  fifo_rd_en, pkt_req, pkt_len, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains the read side of the async byte FIFO into length-committed packets:
// full PKT_LEN when buffered, otherwise a short packet after TIMEOUT idle cycles.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 11,
    parameter int PKT_LEN     = 1024,
    parameter int TIMEOUT     = 65535
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    fifo_pkt_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, STREAM} state_t;

    localparam logic [15:0] PKT_LEN_W = 16'(PKT_LEN);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [15:0]            pkt_len_q, pkt_len_d;
    logic [15:0]            tmo_q, tmo_d;
    logic [15:0]            rd_req_cnt_q, rd_req_cnt_d;
    logic [15:0]            tx_cnt_q, tx_cnt_d;
    logic                   inflight_q;
    logic [1:0]             skid_cnt_q, skid_cnt_d;
    logic [DATA_WIDTH-1:0]  skid0_q, skid0_d, skid1_q, skid1_d;

    logic [15:0] level16;
    logic [2:0]  occ_next;
    logic        pkt_full, pkt_timeout, rd_en, m_valid_s, accept, last_beat;

    always_comb begin
        level16     = 16'(bus.fifo_water_level);
        pkt_full    = level16 >= PKT_LEN_W;
        pkt_timeout = (tmo_q == TIMEOUT_W) && (level16 != 16'd0);
        m_valid_s   = skid_cnt_q != 2'd0;
        accept      = m_valid_s && bus.m_ready;
        last_beat   = m_valid_s && (tx_cnt_q == pkt_len_q - 16'd1);
        // Occupancy the skid will hold once this cycle's beat leaves and the
        // in-flight byte lands; counting the departing beat keeps 1 byte/cycle.
        occ_next    = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(accept);
        rd_en       = (state_q == STREAM) && (rd_req_cnt_q < pkt_len_q)
                      && !bus.fifo_rd_empty && (occ_next < 3'd2);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pkt_full || pkt_timeout) state_d = REQ;
            REQ:     if (bus.pkt_ack) state_d = STREAM;
            STREAM:  if (accept && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = rd_en;
        bus.pkt_req    = state_q == REQ;
        bus.pkt_len    = pkt_len_q;
        bus.busy       = state_q != IDLE;
        bus.m_valid    = m_valid_s;
        bus.m_data     = skid0_q;
        bus.m_last     = last_beat;
    end

    always_comb begin
        pkt_len_d = pkt_len_q;
        if (state_q == IDLE) begin
            if (pkt_full)         pkt_len_d = PKT_LEN_W;
            else if (pkt_timeout) pkt_len_d = level16;
        end

        tmo_d = tmo_q;
        if (state_q != IDLE || state_d != IDLE || level16 == 16'd0 || pkt_full)
            tmo_d = '0;
        else if (tmo_q != TIMEOUT_W)
            tmo_d = tmo_q + 16'd1;

        rd_req_cnt_d = (state_q == STREAM) ? rd_req_cnt_q + 16'(rd_en) : '0;
        tx_cnt_d     = (state_q == STREAM) ? tx_cnt_q + 16'(accept) : '0;

        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        unique case ({inflight_q, accept})
            2'b10: begin
                if (skid_cnt_q == 2'd0) skid0_d = bus.fifo_rd_data;
                else                    skid1_d = bus.fifo_rd_data;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = bus.fifo_rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = bus.fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            pkt_len_q    <= '0;
            tmo_q        <= '0;
            rd_req_cnt_q <= '0;
            tx_cnt_q     <= '0;
            inflight_q   <= 1'b0;
            skid_cnt_q   <= '0;
            skid0_q      <= '0;
            skid1_q      <= '0;
        end else begin
            pkt_len_q    <= pkt_len_d;
            tmo_q        <= tmo_d;
            rd_req_cnt_q <= rd_req_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            inflight_q   <= rd_en;
            skid_cnt_q   <= skid_cnt_d;
            skid0_q      <= skid0_d;
            skid1_q      <= skid1_d;
        end
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: behavioural FIFO, packet scoreboard
// checked every cycle, plus hand-computed expectations per scenario.
module tb_fifo_pkt_reader;
    logic clk = 1'b0;
    logic rd_rst;
    always #5 clk = ~clk;

    fifo_pkt_reader_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(11)) bus ();

    fifo_pkt_reader #(
        .DATA_WIDTH(8), .DEPTH_WIDTH(11), .PKT_LEN(1024), .TIMEOUT(100)
    ) dut (
        .rd_clk(clk),
        .rd_rst(rd_rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural FIFO: writes requested by the test land on the next edge.
    logic [7:0]  fq[$];
    int          wr_n = 0;
    int          wr_id = 0;
    int          wr_seen = 0;
    int unsigned wr_seq = 0;

    assign bus.fifo_rd_empty = (bus.fifo_water_level == 12'd0);

    always @(posedge clk) begin
        logic [7:0] b;
        b = bus.fifo_rd_data;
        if (bus.fifo_rd_en && fq.size() > 0) b = fq.pop_front();
        if (wr_id != wr_seen) begin
            for (int i = 0; i < wr_n; i++) begin
                fq.push_back(8'(wr_seq));
                wr_seq++;
            end
            wr_seen = wr_id;
        end
        bus.fifo_rd_data     <= b;
        bus.fifo_water_level <= 12'(fq.size());
    end

    int ready_mode = 0;
    int rcyc = 0;
    always @(negedge clk) begin
        rcyc++;
        if (ready_mode == 0) bus.m_ready = 1'b1;
        else bus.m_ready = ((rcyc % 4 == 0) || (rcyc % 4 == 3)) && ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every popped byte must come out once, in order, within the
    // committed length, with m_last exactly on the final beat.
    logic [7:0] pend[$];
    logic [7:0] prev_data, last_data, e;
    bit  req_seen = 0, in_stream = 0, prev_stall = 0, prev_rst = 0;
    int  cur_len = 0, beats = 0, pops = 0, done_beats = 0, pkts_done = 0;

    always begin
        @(negedge clk);
        #2;
        if (rd_rst) begin
            pend.delete();
            req_seen = 0; in_stream = 0; beats = 0; pops = 0;
            prev_stall = 0; prev_rst = 1;
        end else begin
            if (prev_rst) begin
                chk(bus.m_valid == 0, "rst_m_valid", bus.m_valid, 0);
                chk(bus.fifo_rd_en == 0, "rst_rd_en", bus.fifo_rd_en, 0);
                chk(bus.busy == 0, "rst_busy", bus.busy, 0);
                chk(bus.pkt_req == 0, "rst_pkt_req", bus.pkt_req, 0);
                chk(bus.m_last == 0, "rst_m_last", bus.m_last, 0);
                chk(bus.pkt_len == 0, "rst_pkt_len", bus.pkt_len, 0);
                chk(bus.m_data == 0, "rst_m_data", bus.m_data, 0);
            end
            prev_rst = 0;
            if (bus.fifo_rd_en)
                chk(!bus.fifo_rd_empty, "rd_en_when_empty", bus.fifo_rd_empty, 0);
            if (bus.pkt_req && !req_seen) begin
                req_seen = 1; cur_len = bus.pkt_len; beats = 0; pops = 0;
            end
            if (req_seen) chk(bus.pkt_len == cur_len, "pkt_len_stable", bus.pkt_len, cur_len);
            if (req_seen || bus.pkt_req || bus.m_valid)
                chk(bus.busy == 1, "busy", bus.busy, 1);
            if (!in_stream) begin
                chk(bus.fifo_rd_en == 0, "rd_en_outside_stream", bus.fifo_rd_en, 0);
                chk(bus.m_valid == 0, "m_valid_outside_stream", bus.m_valid, 0);
            end
            if (prev_stall) begin
                chk(bus.m_valid == 1, "hold_valid", bus.m_valid, 1);
                chk(bus.m_data == prev_data, "hold_data", bus.m_data, prev_data);
            end
            if (bus.fifo_rd_en && fq.size() > 0) begin
                pend.push_back(fq[0]);
                pops++;
                chk(pops <= cur_len, "pops_le_len", pops, cur_len);
            end
            if (bus.m_valid)
                chk(bus.m_last == (beats == cur_len - 1), "m_last", bus.m_last, beats == cur_len - 1);
            if (bus.m_valid && bus.m_ready) begin
                chk(pend.size() > 0, "data_unexpected", bus.m_data, -1);
                if (pend.size() > 0) begin
                    e = pend.pop_front();
                    chk(bus.m_data == e, "data_order", bus.m_data, e);
                end
                beats++;
                last_data = bus.m_data;
                if (bus.m_last) begin
                    chk(pops == cur_len, "pop_count", pops, cur_len);
                    done_beats = beats;
                    pkts_done++;
                    req_seen = 0;
                    in_stream = 0;
                end
            end
            chk(pend.size() <= 2, "skid_occupancy", pend.size(), 2);
            if (bus.pkt_req && bus.pkt_ack) in_stream = 1;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic write_bytes(input int n);
        @(negedge clk);
        wr_n = n;
        wr_id++;
    endtask

    task automatic wait_req(input int exp_len, input int bound, output int n);
        n = 0;
        while (!bus.pkt_req && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(bus.pkt_req == 1, "req_arrival", n, bound);
        chk(bus.pkt_len == exp_len, "pkt_len", bus.pkt_len, exp_len);
    endtask

    task automatic do_ack(input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        bus.pkt_ack = 1'b1;
        @(negedge clk);
        bus.pkt_ack = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int start, n;
        start = pkts_done;
        n = 0;
        while (pkts_done == start && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(pkts_done != start, "pkt_done", n, bound);
    endtask

    initial begin
        int n, resid;
        rd_rst = 1'b1;
        bus.pkt_ack = 1'b0;
        repeat (3) @(negedge clk);
        rd_rst = 1'b0;

        // ack while idle and empty is ignored
        do_ack(0);
        repeat (3) @(negedge clk);
        chk(bus.busy == 0, "ack_idle", bus.busy, 0);

        // full packet of 1024, bytes 0x00..0xFF repeating
        write_bytes(1024);
        wait_req(1024, 10, n);
        do_ack(0);
        wait_done(1100);
        chk(done_beats == 1024, "t1_beats", done_beats, 1024);
        chk(last_data == 8'hFF, "t1_last_byte", last_data, 8'hFF);
        @(negedge clk);
        chk(bus.busy == 0, "t1_idle", bus.busy, 0);

        // short packet flushed by timeout
        write_bytes(5);
        wait_req(5, 200, n);
        chk(n >= 99 && n <= 104, "t2_timeout_cycles", n, 102);
        do_ack(0);
        wait_done(50);
        chk(done_beats == 5, "t2_beats", done_beats, 5);
        chk(last_data == 8'h04, "t2_last_byte", last_data, 8'h04);

        // stalls on the stream side
        ready_mode = 1;
        write_bytes(1024);
        wait_req(1024, 10, n);
        do_ack(0);
        wait_done(8000);
        ready_mode = 0;
        chk(done_beats == 1024, "t3_beats", done_beats, 1024);
        chk(last_data == 8'h04, "t3_last_byte", last_data, 8'h04);

        // back-to-back packets with no timeout wait
        write_bytes(2048);
        wait_req(1024, 10, n);
        do_ack(0);
        wait_done(1100);
        wait_req(1024, 4, n);
        do_ack(0);
        wait_done(1100);
        @(negedge clk);
        chk(bus.fifo_water_level == 0, "t4_fifo_empty", bus.fifo_water_level, 0);

        // reset in the middle of a packet
        write_bytes(1024);
        wait_req(1024, 10, n);
        do_ack(0);
        n = 0;
        while (beats < 300 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(beats >= 300, "t5_reach_300", beats, 300);
        rd_rst = 1'b1;
        @(negedge clk);
        rd_rst = 1'b0;
        repeat (2) @(negedge clk);
        resid = int'(bus.fifo_water_level);
        chk(resid >= 720 && resid <= 724, "t5_residual", resid, 724);
        wait_req(resid, 250, n);
        do_ack(0);
        wait_done(1000);
        chk(done_beats == resid, "t5_beats", done_beats, resid);

        // ack withheld while more bytes arrive
        write_bytes(10);
        wait_req(10, 200, n);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) begin
                wr_n = 20;
                wr_id++;
            end
            chk(bus.pkt_req == 1, "t6_req_held", bus.pkt_req, 1);
            chk(bus.pkt_len == 10, "t6_len_held", bus.pkt_len, 10);
        end
        do_ack(0);
        wait_done(50);
        chk(done_beats == 10, "t6_beats", done_beats, 10);
        wait_req(20, 200, n);
        do_ack(0);
        wait_done(60);
        chk(done_beats == 20, "t6_rest_beats", done_beats, 20);

        // single-byte packet
        write_bytes(1);
        wait_req(1, 200, n);
        do_ack(0);
        n = 0;
        while (!bus.m_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(bus.m_valid == 1 && bus.m_last == 1, "t7_single_last", bus.m_last, 1);
        wait_done(10);
        chk(done_beats == 1, "t7_beats", done_beats, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
